idex_stage: RTL

ID/EX pipeline register plus operand-forwarding and load-use hazard logic for the pipelined CPU. It sits directly upstream of the ALU. It captures the decoded instruction from ID each cycle and drives the ALU's `ALU_DA`, `ALU_DB` and `ALUCLT` inputs with the correct, possibly forwarded, operands. It also raises the load-use stall request back to IF/ID and carries the control fields that EX/MEM needs.

---
 rtl/idex_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/idex_stage.sv
// -----------------------------------------------------------------------------
// idex_stage
//
// ID/EX pipeline register for the pipelined CPU. It also holds the operand
// forwarding muxes that feed the ALU and the load-use hazard detector.
//
// The register captures the decoded ID instruction. On the EX side it drives:
//   ALU_DA / ALU_DB  ALU operands. Each is a forwarded rs1/rs2 value, or the
//                    registered PC/immediate.
//   ALUCLT           ALU operation code, taken straight from the register.
//   ex_store_data    Forwarded rs2 value, for stores.
//   ex_*             Registered control bits, destination register and PC,
//                    consumed by EX/MEM.
//   hazard_stall     Load-use stall request back to the PC and IF/ID.
//
// Ports
//   clk, rst_n                   rising-edge clock, async active-low reset
//   id_*                         decoded instruction fields from ID
//   stall                        global hold (memory wait)
//   flush                        squash the instruction entering EX
//   exmem_rd/_reg_write/_result  EX/MEM forwarding source
//   memwb_rd/_reg_write/_result  MEM/WB forwarding source
// -----------------------------------------------------------------------------
module idex_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [RA_W-1:0] id_rs1_addr,
   input  logic [RA_W-1:0] id_rs2_addr,
   input  logic [RA_W-1:0] id_rd_addr,
   input  logic            id_alu_src_a,
   input  logic            id_alu_src_b,
   input  logic [3:0]      id_aluclt,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            stall,
   input  logic            flush,
   input  logic [RA_W-1:0] exmem_rd,
   input  logic            exmem_reg_write,
   input  logic [XLEN-1:0] exmem_result,
   input  logic [RA_W-1:0] memwb_rd,
   input  logic            memwb_reg_write,
   input  logic [XLEN-1:0] memwb_result,
   output logic [XLEN-1:0] ALU_DA,
   output logic [XLEN-1:0] ALU_DB,
   output logic [3:0]      ALUCLT,
   output logic [XLEN-1:0] ex_store_data,
   output logic            ex_valid,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic [RA_W-1:0] ex_rd,
   output logic [XLEN-1:0] ex_pc,
   output logic            hazard_stall
);

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [RA_W-1:0] rs1_addr;
      logic [RA_W-1:0] rs2_addr;
      logic [RA_W-1:0] rd;
      logic            alu_src_a;
      logic            alu_src_b;
      logic [3:0]      aluclt;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
   } ex_reg_t;

   // A bubble is the all-zero instruction: invalid, writes nothing, aluclt = add.
   localparam ex_reg_t BUBBLE = '0;

   ex_reg_t ex_q;
   ex_reg_t ex_d;
   ex_reg_t id_fields;

   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;

   always_comb begin
      id_fields           = BUBBLE;
      id_fields.valid     = id_valid;
      id_fields.pc        = id_pc;
      id_fields.rs1_data  = id_rs1_data;
      id_fields.rs2_data  = id_rs2_data;
      id_fields.imm       = id_imm;
      id_fields.rs1_addr  = id_rs1_addr;
      id_fields.rs2_addr  = id_rs2_addr;
      id_fields.rd        = id_rd_addr;
      id_fields.alu_src_a = id_alu_src_a;
      id_fields.alu_src_b = id_alu_src_b;
      id_fields.aluclt    = id_aluclt;
      id_fields.reg_write = id_reg_write;
      id_fields.mem_read  = id_mem_read;
      id_fields.mem_write = id_mem_write;
   end

   // A load in EX cannot supply its data until MEM/WB. An ID instruction that
   // reads the load's rd must therefore wait one cycle. Upstream decides how
   // this combines with stall/flush, so neither is folded in here.
   assign hazard_stall = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid &
                         ((ex_q.rd == id_rs1_addr) | (ex_q.rd == id_rs2_addr));

   // Update priority: flush > stall (hold) > load-use bubble > capture.
   always_comb begin
      // NOTE: ex_d gets a value before any branching, so no path leaves it
      // unassigned and no latch is inferred.
      ex_d = ex_q;
      if (flush)             ex_d = BUBBLE;
      else if (stall)        ex_d = ex_q;
      else if (hazard_stall) ex_d = BUBBLE;
      else                   ex_d = id_fields;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with non-blocking assignments, so every flop
      // samples the pre-edge value of its inputs regardless of process order.
      if (!rst_n) ex_q <= BUBBLE;
      else        ex_q <= ex_d;
   end

   // Forwarding uses the registered source addresses. EX/MEM holds the
   // younger result and wins. x0 is hard-wired zero, so it is never forwarded.
   always_comb begin
      rs1_fwd = ex_q.rs1_data;
      if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rs1_addr)
         rs1_fwd = exmem_result;
      else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rs1_addr)
         rs1_fwd = memwb_result;
   end

   always_comb begin
      rs2_fwd = ex_q.rs2_data;
      if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rs2_addr)
         rs2_fwd = exmem_result;
      else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rs2_addr)
         rs2_fwd = memwb_result;
   end

   assign ALU_DA        = ex_q.alu_src_a ? ex_q.pc  : rs1_fwd;
   assign ALU_DB        = ex_q.alu_src_b ? ex_q.imm : rs2_fwd;
   assign ALUCLT        = ex_q.aluclt;
   // Stores need the forwarded rs2 even though ALU_DB carries the offset.
   assign ex_store_data = rs2_fwd;
   assign ex_valid      = ex_q.valid;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_rd         = ex_q.rd;
   assign ex_pc         = ex_q.pc;

endmodule
